// File: rtl/stream_mux_arb_if.sv
// rtl/stream_mux_arb_if.sv - handshake bundle between N producers, the mux and one consumer
interface stream_mux_arb_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N:1 stream mux with select / round-robin / priority grant and a registered output
module stream_mux_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 1
) (
    input logic             clk,
    input logic             rst,
    stream_mux_arb_if.slave bus
);
    localparam int SELW = $clog2(N);
    localparam int SW1  = SELW + 1;

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] gidx;
    logic [SELW:0]   sum;
    logic            found;
    logic            load;
    logic [N-1:0]    grant;

    assign load         = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = grant & {N{load}};

    // Search starts at rr_ptr for round-robin, at 0 for fixed priority; wrap without a modulo.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        sum   = '0;
        if (MODE == 0) begin
            if (({1'b0, bus.sel} < SW1'(N)) && bus.in_valid[bus.sel]) begin
                found = 1'b1;
                gidx  = bus.sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                sum = (MODE == 1) ? ({1'b0, rr_ptr} + SW1'(k)) : SW1'(k);
                if (sum >= SW1'(N)) begin
                    sum = sum - SW1'(N);
                end
                if (!found && bus.in_valid[sum[SELW-1:0]]) begin
                    found = 1'b1;
                    gidx  = sum[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            if (found) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
                bus.out_src   <= gidx;
                if (MODE == 1) begin
                    rr_ptr <= ({1'b0, gidx} == SW1'(N - 1)) ? '0 : gidx + SELW'(1);
                end
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - bench for stream_mux_arb in all three modes against a rule-level model
module tb_stream_mux_arb;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [1:0]     sel;
    logic           out_ready;

    int tests = 0;
    int fails = 0;

    stream_mux_arb_if #(.WIDTH(W), .N(N)) if_sel (), if_rr (), if_pri ();

    assign if_sel.in_data   = in_data;
    assign if_sel.in_valid  = in_valid;
    assign if_sel.sel       = sel;
    assign if_sel.out_ready = out_ready;
    assign if_rr.in_data    = in_data;
    assign if_rr.in_valid   = in_valid;
    assign if_rr.sel        = sel;
    assign if_rr.out_ready  = out_ready;
    assign if_pri.in_data   = in_data;
    assign if_pri.in_valid  = in_valid;
    assign if_pri.sel       = sel;
    assign if_pri.out_ready = out_ready;

    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(0)) u_sel (.clk(clk), .rst(rst), .bus(if_sel));
    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(if_rr));
    stream_mux_arb #(.WIDTH(W), .N(N), .MODE(2)) u_pri (.clk(clk), .rst(rst), .bus(if_pri));

    always #5 clk = ~clk;

    // Index 0 = external select, 1 = round-robin, 2 = fixed priority
    logic [N-1:0] rdy [3];
    logic         ov  [3];
    logic [W-1:0] od  [3];
    logic [1:0]   os  [3];

    assign rdy[0] = if_sel.in_ready;
    assign rdy[1] = if_rr.in_ready;
    assign rdy[2] = if_pri.in_ready;
    assign ov[0]  = if_sel.out_valid;
    assign ov[1]  = if_rr.out_valid;
    assign ov[2]  = if_pri.out_valid;
    assign od[0]  = if_sel.out_data;
    assign od[1]  = if_rr.out_data;
    assign od[2]  = if_pri.out_data;
    assign os[0]  = if_sel.out_src;
    assign os[1]  = if_rr.out_src;
    assign os[2]  = if_pri.out_src;

    bit       mv [3];
    bit [W-1:0] md [3];
    int       ms [3];
    int       mptr;

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            mv[m] = 1'b0;
            md[m] = '0;
            ms[m] = 0;
        end
        mptr = 0;
    endtask

    // Winner = valid channel with the smallest distance: rotated from mptr for RR, raw index for priority.
    function automatic int pick(int m);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        if (m == 0) begin
            return in_valid[sel] ? int'(sel) : -1;
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                d = (m == 1) ? (i - mptr + N) % N : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int g  [3];
        bit ld [3];
        #1;
        for (int m = 0; m < 3; m++) begin
            g[m]  = pick(m);
            ld[m] = !mv[m] || out_ready;
            chk($sformatf("in_ready[m%0d]", m), 32'(rdy[m]),
                (g[m] >= 0 && ld[m]) ? (32'd1 << g[m]) : 32'd0);
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (ld[m]) begin
                if (g[m] >= 0) begin
                    mv[m] = 1'b1;
                    md[m] = in_data[g[m]*W +: W];
                    ms[m] = g[m];
                    if (m == 1) mptr = (g[m] + 1) % N;
                end else begin
                    mv[m] = 1'b0;
                end
            end
        end
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("out_valid[m%0d]", m), 32'(ov[m]), 32'(mv[m]));
            chk($sformatf("out_data[m%0d]", m), 32'(od[m]), 32'(md[m]));
            chk($sformatf("out_src[m%0d]", m), 32'(os[m]), 32'(ms[m]));
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 3; m++) begin
            chk("reset_valid", 32'(ov[m]), 32'd0);
            chk("reset_data", 32'(od[m]), 32'd0);
            chk("reset_src", 32'(os[m]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with every channel valid
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_seq_src", 32'(os[1]), 32'(k % 4));
            chk("rr_seq_valid", 32'(ov[1]), 32'd1);
        end

        // Asynchronous reset with a beat held
        rst = 1'b1;
        #2;
        model_reset();
        for (int m = 0; m < 3; m++) begin
            chk("midreset_valid", 32'(ov[m]), 32'd0);
            chk("midreset_data", 32'(od[m]), 32'd0);
            chk("midreset_src", 32'(os[m]), 32'd0);
        end
        rst = 1'b0;
        cycle();
        chk("post_reset_src", 32'(os[1]), 32'd0);

        // Round-robin wrap: ch2 accept sets pointer to 3, then 0 and 1 follow
        in_valid = 4'b0100;
        cycle();
        chk("wrap_ch2", 32'(os[1]), 32'd2);
        in_valid = 4'b0011;
        cycle();
        chk("wrap_ch0", 32'(os[1]), 32'd0);
        cycle();
        chk("wrap_ch1", 32'(os[1]), 32'd1);

        // Backpressure hold, then drain and refill in the same edge
        in_valid = 4'b0001;
        in_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
        cycle();
        chk("bp_load", 32'(od[1]), 32'hA5);
        out_ready = 1'b0;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h3C};
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_data", 32'(od[1]), 32'hA5);
            chk("bp_hold_ready", 32'(rdy[1]), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_refill_data", 32'(od[1]), 32'h3C);
        chk("bp_refill_valid", 32'(ov[1]), 32'd1);

        // Fixed priority
        in_data  = {8'h43, 8'h42, 8'h41, 8'h40};
        in_valid = 4'b1100;
        cycle();
        chk("pri_ch2", 32'(os[2]), 32'd2);
        chk("pri_ch2_data", 32'(od[2]), 32'h42);
        in_valid = 4'b1110;
        cycle();
        chk("pri_ch1", 32'(os[2]), 32'd1);
        cycle();
        chk("pri_starve", 32'(os[2]), 32'd1);

        // External select
        sel      = 2'd2;
        in_valid = 4'b1011;
        cycle();
        chk("sel_nogrant", 32'(ov[0]), 32'd0);
        sel = 2'd3;
        cycle();
        chk("sel3_valid", 32'(ov[0]), 32'd1);
        chk("sel3_src", 32'(os[0]), 32'd3);
        chk("sel3_data", 32'(od[0]), 32'h43);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom % 4) != 0;
            sel       = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
